uart_prog_loader: RTL



---
 rtl/uart_prog_pkg.sv | 34 +++
 rtl/uart_prog_skid.sv | 35 +++
 rtl/uart_prog_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader: FSM encoding,
// byte/word geometry and the default end-of-program marker.
package uart_prog_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned IDX_W          = 2;

  localparam logic [WORD_W-1:0] EOP_WORD_DEF = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Little-endian placement of byte idx into a 32-bit word.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      default: res[31:24] = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_prog_skid.sv
// One-entry byte buffer that absorbs a received byte while the loader is busy
// evaluating or writing a word; reports a push that finds it already full.
module uart_prog_skid
  import uart_prog_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic              valid,
  output logic [BYTE_W-1:0] dout,
  output logic              ovf_c
);

  // A pop in the same cycle frees the slot, so a simultaneous push is accepted.
  assign ovf_c = push & valid & ~pop & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (push && (!valid || pop)) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: assembles little-endian words from UART bytes, writes them to
// instruction memory at consecutive addresses, and stops on the EOP marker.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int unsigned       MEM_WORDS = 1024,
  parameter int unsigned       ADDR_W    = $clog2(MEM_WORDS),
  parameter logic [WORD_W-1:0] EOP_WORD  = EOP_WORD_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      rx_dv_i,
  input  logic [BYTE_W-1:0]         rx_byte_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [BYTES_PER_WORD-1:0] mem_be_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [WORD_W-1:0]         mem_wdata_o,
  input  logic                      mem_gnt_i,
  output logic [ADDR_W:0]           word_cnt_o,
  output logic                      done_o,
  output logic                      overrun_err_o,
  output logic                      full_err_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                word_ready_q, word_ready_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                full_q, full_d;

  logic                in_collect, in_write, evaluating, grant;
  logic                is_eop, mem_full, clear;
  logic                skid_valid, skid_push, skid_pop, skid_ovf;
  logic [BYTE_W-1:0]   skid_dout, in_byte;
  logic                direct_take, consume;

  assign in_collect = (state_q == ST_COLLECT);
  assign in_write   = (state_q == ST_WRITE);
  assign evaluating = in_collect & word_ready_q;
  assign grant      = in_write & mem_gnt_i;
  assign is_eop     = (shift_q == EOP_WORD);
  assign mem_full   = (cnt_q == (ADDR_W+1)'(MEM_WORDS));
  assign clear      = (state_d == ST_IDLE);

  // Buffered byte takes priority over a new arrival so ordering is preserved.
  assign skid_pop    = in_collect & ~word_ready_q & skid_valid;
  assign direct_take = in_collect & ~word_ready_q & ~skid_valid & rx_dv_i;
  assign skid_push   = rx_dv_i & ((in_collect & (word_ready_q | skid_valid)) | in_write);
  assign consume     = skid_pop | direct_take;
  assign in_byte     = skid_pop ? skid_dout : rx_byte_i;

  uart_prog_skid u_skid (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clear),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (rx_byte_i),
    .valid (skid_valid),
    .dout  (skid_dout),
    .ovf_c (skid_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!en_i)                 state_d = ST_IDLE;
        else if (word_ready_q) begin
          if (is_eop || mem_full)  state_d = ST_DONE;
          else                     state_d = ST_WRITE;
        end
      end
      // A pending write always completes before honouring a disable.
      ST_WRITE: begin
        if (mem_gnt_i) state_d = en_i ? ST_COLLECT : ST_IDLE;
      end
      ST_DONE: begin
        if (!en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    shift_d      = shift_q;
    word_ready_d = word_ready_q;
    req_d        = (state_d == ST_WRITE);
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    done_d       = (state_d == ST_DONE);
    ovr_d        = ovr_q;
    full_d       = full_q;

    if (clear) begin
      idx_d        = '0;
      shift_d      = '0;
      word_ready_d = 1'b0;
      req_d        = 1'b0;
      addr_d       = '0;
      wdata_d      = '0;
      cnt_d        = '0;
      done_d       = 1'b0;
      ovr_d        = 1'b0;
      full_d       = 1'b0;
    end else begin
      if (evaluating) begin
        word_ready_d = 1'b0;
        if (!is_eop && mem_full) full_d = 1'b1;
        if (state_d == ST_WRITE) begin
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = shift_q;
        end
      end
      if (consume) begin
        shift_d = place_byte(shift_q, idx_q, in_byte);
        idx_d   = IDX_W'(idx_q + 2'd1);
        if (idx_q == 2'd3) word_ready_d = 1'b1;
      end
      if (grant)    cnt_d = (ADDR_W+1)'(cnt_q + 1'b1);
      if (skid_ovf) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q        <= '0;
      shift_q      <= '0;
      word_ready_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      word_ready_q <= word_ready_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      full_q       <= full_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = req_q;
  assign mem_be_o      = {BYTES_PER_WORD{req_q}};
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign word_cnt_o    = cnt_q;
  assign done_o        = done_q;
  assign overrun_err_o = ovr_q;
  assign full_err_o    = full_q;

endmodule
